// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a word-only data RAM: aligned word accesses,
// sign/zero extension on loads and read-modify-write for sub-word stores.
module mem_access_ctrl #(
    parameter int MEM_BYTES = 128
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [1:0]  resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_datain,
    input  logic [31:0] ram_dataout,
    output logic        ram_write,
    output logic        ram_read
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;

    state_t      state, next_state;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [1:0]  lat_off;
    logic [15:0] lat_wdata;

    logic        misaligned, out_of_range;
    logic [31:0] load_value, merged_word;

    // Extracts the addressed lane of a RAM word and extends it to 32 bits.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic uns, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_BYTE: extract = {{24{~uns & b[7]}}, b};
            SZ_HALF: extract = {{16{~uns & h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [15:0] wd,
                                          input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] r;
        r = w;
        if (sz == SZ_BYTE)
            r[{off, 3'b000} +: 8] = wd[7:0];
        else if (off[1])
            r[31:16] = wd;
        else
            r[15:0] = wd;
        return r;
    endfunction

    assign misaligned   = ((req_size == SZ_HALF) && req_addr[0]) ||
                          (req_size[1] && (req_addr[1:0] != 2'b00));
    assign out_of_range = req_addr >= 32'(MEM_BYTES);
    assign load_value   = extract(ram_dataout, lat_size, lat_unsigned, lat_off);
    assign merged_word  = merge(ram_dataout, lat_wdata, lat_size, lat_off);

    // Strobes come from the state register only; Reset masks them so no
    // RAM write can land on an edge where the controller is being reset.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign ram_read   = !Reset && ((state == LOAD) || (state == RMW_RD));
    assign ram_write  = !Reset && (state == WRITE);

    // NOTE: every output of this block gets a default before the case, so no
    // path through it leaves a value unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned || out_of_range) next_state = RESP;
                    else if (!req_we)               next_state = LOAD;
                    else if (req_size[1])           next_state = WRITE;
                    else                            next_state = RMW_RD;
                end
            end
            LOAD:    next_state = RESP;
            RMW_RD:  next_state = WRITE;
            WRITE:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            lat_size     <= SZ_BYTE;
            lat_unsigned <= 1'b0;
            lat_off      <= 2'b00;
            lat_wdata    <= '0;
            ram_addr     <= '0;
            ram_datain   <= '0;
            resp_err     <= ERR_OK;
            resp_rdata   <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_off      <= req_addr[1:0];
                        lat_wdata    <= req_wdata[15:0];
                        ram_addr     <= {req_addr[31:2], 2'b00};
                        ram_datain   <= req_we ? req_wdata : '0;
                        resp_rdata   <= '0;
                        resp_err     <= misaligned   ? ERR_ALIGN :
                                        out_of_range ? ERR_RANGE : ERR_OK;
                    end
                end
                LOAD:   resp_rdata <= load_value;
                RMW_RD: ram_datain <= merged_word;
                RESP: begin
                    resp_err   <= ERR_OK;
                    resp_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
